// File: rtl/serdes_rx_pkg.sv
// rtl/serdes_rx_pkg.sv - shared types and constants for the SerDes receive deframer
// Purpose: deframer state encoding, default framing byte and PRBS7 feedback taps.
// Ports: none (package).
package serdes_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA7;

    // x^7 + x^6 + 1: with bit 0 holding the newest bit, the taps are the
    // bits received 7 and 6 strobes ago.
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

endpackage

// File: rtl/serdes_prbs7_chk.sv
// rtl/serdes_prbs7_chk.sv - bit-serial PRBS7 seed/compare/error-count checker
// Purpose: seeds from the first 7 bits after restart_i, then predicts every
//          further bit and counts mismatches in a saturating 16-bit counter.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   restart_i   reseed on the next 7 enabled bits (error count is kept)
//   bit_en_i    bit_i is a checked stream bit this cycle
//   bit_i       received bit
//   err_cnt_o   saturating error count, cleared only by rst
module serdes_prbs7_chk
    import serdes_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        restart_i,
    input  logic        bit_en_i,
    input  logic        bit_i,
    output logic [15:0] err_cnt_o
);

    logic [6:0]  lfsr_q, lfsr_d;
    logic [2:0]  seed_cnt_q, seed_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        predicted;

    always_comb begin
        lfsr_d     = lfsr_q;
        seed_cnt_d = seed_cnt_q;
        err_cnt_d  = err_cnt_q;
        predicted  = ^(lfsr_q & PRBS7_TAPS);
        if (restart_i) begin
            seed_cnt_d = 3'd0;
        end else if (bit_en_i) begin
            if (seed_cnt_q != 3'd7) begin
                lfsr_d     = {lfsr_q[5:0], bit_i};
                seed_cnt_d = seed_cnt_q + 3'd1;
            end else begin
                // Run on the prediction so one flipped bit counts exactly once.
                lfsr_d = {lfsr_q[5:0], predicted};
                if ((bit_i != predicted) && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= '0;
            seed_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            seed_cnt_q <= seed_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/serdes_rx_deframer.sv
// rtl/serdes_rx_deframer.sv - serial receive deframer with sync hunt and lock hysteresis
// Purpose: hunts SYNC_WORD in the strobed bitstream, locks after LOCK_CNT good
//          sync slots, drops after LOSS_CNT bad ones, and emits FRAME_LEN payload
//          bytes per frame while locked.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_en         bit strobe; all state frozen while low
//   rx_bit        serial data, MSB first
//   data_out      last completed payload byte
//   data_valid    one-cycle pulse with each new payload byte
//   frame_start   pulse with payload byte 0
//   locked        level, high in LOCKED
//   sync_err      one-cycle pulse on a mismatched sync slot while locked
//   prbs_err_cnt  PRBS7 payload error count
// Optional: SERDES_RX_PRBS_CHK_EN adds the PRBS7 payload checker; otherwise
//           prbs_err_cnt is tied to 0.
module serdes_rx_deframer
    import serdes_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int unsigned FRAME_LEN = 7,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_CNT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        rx_bit,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] prbs_err_cnt
);

    localparam int unsigned BW = $clog2(FRAME_LEN + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);
    localparam logic [BW-1:0] SYNC_SLOT = BW'(FRAME_LEN);
    localparam logic [GW-1:0] GOOD_LIM  = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_LIM  = MW'(LOSS_CNT);

    rx_state_e   state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_err_q, sync_err_d;

    logic [7:0]    candidate;
    logic          byte_done;
    logic          sync_slot;
    logic          sync_hit;
    logic [GW-1:0] good_inc;
    logic [MW-1:0] miss_inc;

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        good_d        = good_q;
        miss_d        = miss_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;

        candidate = {sr_q[6:0], rx_bit};
        byte_done = (bit_cnt_q == 3'd7);
        sync_slot = (byte_cnt_q == SYNC_SLOT);
        sync_hit  = (candidate == SYNC_WORD);
        good_inc  = good_q + GW'(1);
        miss_inc  = miss_q + MW'(1);

        if (rx_en) begin
            sr_d      = candidate;
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                ST_HUNT: begin
                    // Bit-by-bit search; a hit defines the byte alignment.
                    if (sync_hit) begin
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = '0;
                        good_d     = GW'(1);
                        miss_d     = '0;
                        state_d    = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (byte_done) begin
                        if (sync_slot) begin
                            byte_cnt_d = '0;
                            if (sync_hit) begin
                                good_d = good_inc;
                                if (good_inc == GOOD_LIM) begin
                                    state_d = ST_LOCKED;
                                end
                            end else begin
                                state_d = ST_HUNT;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (byte_done) begin
                        if (sync_slot) begin
                            byte_cnt_d = '0;
                            if (sync_hit) begin
                                miss_d = '0;
                            end else begin
                                sync_err_d = 1'b1;
                                miss_d     = miss_inc;
                                if (miss_inc == MISS_LIM) begin
                                    state_d = ST_HUNT;
                                end
                            end
                        end else begin
                            // Payload flows even while sync slots are missing.
                            data_out_d    = candidate;
                            data_valid_d  = 1'b1;
                            frame_start_d = (byte_cnt_q == '0);
                            byte_cnt_d    = byte_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            good_q        <= '0;
            miss_q        <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            good_q        <= good_d;
            miss_q        <= miss_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_LOCKED);

`ifdef SERDES_RX_PRBS_CHK_EN
    logic prbs_restart;
    logic prbs_bit_en;

    // Reseed on every entry to LOCKED; sync-slot bits never reach the checker.
    assign prbs_restart = (state_q != ST_LOCKED) && (state_d == ST_LOCKED);
    assign prbs_bit_en  = (state_q == ST_LOCKED) && rx_en && !sync_slot;

    serdes_prbs7_chk u_prbs7_chk (
        .clk       (clk),
        .rst       (rst),
        .restart_i (prbs_restart),
        .bit_en_i  (prbs_bit_en),
        .bit_i     (rx_bit),
        .err_cnt_o (prbs_err_cnt)
    );
`else
    assign prbs_err_cnt = 16'h0000;
`endif

endmodule

// File: doc/serdes_rx_deframer.md
# serdes_rx_deframer

Receive-side deframer for the SerDes PHY. It takes the recovered serial bitstream one bit per strobe and hunts for the framing sync byte. It acquires and holds frame lock with hysteresis, and delivers payload bytes with a valid pulse to the core logic. It is the counterpart of the transmit framer, which emits one sync byte followed by `FRAME_LEN` payload bytes, MSB first.

## Interface
- `SYNC_WORD`, 8'hA7: framing byte, must be nonzero.
- `FRAME_LEN`, 7: payload bytes per frame, 1..255.
- `LOCK_CNT`, 3: consecutive good sync bytes required to lock, ≥1.
- `LOSS_CNT`, 4: consecutive bad sync bytes required to drop lock, ≥1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rx_en`  in  1: bit strobe; `rx_bit` is consumed only when high.
- `rx_bit`  in  1: serial data, MSB of each byte first.
- `data_out`  out  8: last completed payload byte.
- `data_valid`  out  1: one-cycle pulse, `data_out` is new.
- `frame_start`  out  1: pulse coincident with `data_valid` for payload byte 0.
- `locked`  out  1: level, high in LOCKED.
- `sync_err`  out  1: one-cycle pulse, sync slot mismatched while LOCKED.
- `prbs_err_cnt`  out  16: PRBS bit-error count; constant 0 when the macro is absent.

## Operation
- Shift register `sr[7:0]`, loaded as `{sr[6:0], rx_bit}` on each `rx_en`. Byte candidate is `{sr[6:0], rx_bit}`.
- **HUNT:** compare on every strobed bit. On match, go to VERIFY with bit_cnt=0, byte_cnt=0, good=1.
- **VERIFY:**
  - A byte completes every 8 strobed bits. byte_cnt runs 0..FRAME_LEN and wraps to 0 after the sync slot (index FRAME_LEN).
  - No payload output in this state.
  - At the sync slot, a match increments good; when good reaches LOCK_CNT, go to LOCKED. A mismatch returns to HUNT.
  - With LOCK_CNT=1, the transition from HUNT goes straight to LOCKED.
- **LOCKED:**
  - Payload bytes (byte_cnt 0..FRAME_LEN-1) are output with `data_valid`.
  - At the sync slot, a match clears miss. A mismatch pulses `sync_err` and increments miss; miss reaching LOSS_CNT goes to HUNT.
  - Payload keeps flowing during misses (flywheel).
- Counter widths are clog2(FRAME_LEN+1) for byte_cnt, 3 bits for bit_cnt, and clog2 of the respective limit +1 for good/miss.

## Timing
- Reset values: all outputs 0, state HUNT, `sr`=0, all counters 0. Reset mid-frame forces HUNT on the next edge and discards any partial byte.
- Output latency: `data_valid`, `data_out`, `frame_start`, `sync_err` and `locked` are registered. They change on the edge after the `rx_en` cycle that delivered the completing bit.
- Pulse outputs deassert on any cycle without a completing bit. `rx_en` low freezes all state.
- `locked` falls on the same edge as the LOSS_CNT-th `sync_err` pulse. No `data_valid` is emitted for any bit processed in HUNT.
- `rx_bit` is don't-care when `rx_en` is low. There is no backpressure; the consumer must accept every `data_valid`.

## Configuration
- `SERDES_RX_PRBS_CHK_EN` defined: a PRBS7 checker (x^7+x^6+1) runs on payload bits while LOCKED.
  - The first 7 payload bits after each lock seed the checker. Each later payload bit is compared to the prediction, and mismatches increment `prbs_err_cnt`.
  - The counter saturates at 16'hFFFF and clears only on `rst`.
  - Sync bits are excluded. The checker reseeds on every new entry to LOCKED.
- Macro undefined: no checker logic, and `prbs_err_cnt` is tied to 0.

## Structure
- Package `serdes_rx_pkg`: state enum typedef (HUNT, VERIFY, LOCKED), default SYNC_WORD constant, PRBS7 tap constant.
- Sub-module `serdes_prbs7_chk` (bit-serial seed/compare/count) is instantiated only under the macro.
- Everything else is flat in `serdes_rx_deframer`.

## Test plan
- **Lock acquisition:** noise, then 3 frames of A7 + payload 01..07 → `locked` rises after the 3rd sync. `data_valid` ×7 per subsequent frame, `frame_start` with 01, no output before lock.
- **Bit slip:** A7 injected at a non-byte boundary after 3 random bits → alignment follows the sync. The payload of the 4th frame is 01..07 exactly.
- **Loss hysteresis:** while locked, corrupt 3 sync bytes to 00 → 3 `sync_err` pulses, `locked` stays 1. One good sync resets miss. 4 consecutive bad syncs → `locked` falls with the 4th pulse.
- **Strobe gaps:** `rx_en` at 1-in-3 duty with random gaps → identical byte sequence to full rate, and no pulse lasting longer than 1 cycle.
- **Mid-frame reset:** `rst` high 1 cycle at payload byte 3 → next cycle all outputs 0, HUNT. Relock requires 3 full syncs.
- **PRBS (macro on):** PRBS7 payload with 5 single-bit flips injected → `prbs_err_cnt`=5. Macro off → `prbs_err_cnt`=0.
